layer_input_sequencer: RTL and testbench
========================================

# layer_input_sequencer

Controller that sequences the layer-input shift register of the neural-net datapath. It accepts a stream of N-bit activation words over a valid/ready handshake and drives the shift register's write enable and data so that exactly M words form one frame. It pulses a compute start to the neuron array, waits for that array's done, and repeats for F frames per layer before signalling layer completion.

## Interface
- M, 4: words per frame; must equal the shift register depth, M ≥ 2.
- N, 32: word width in bits; must equal the shift register word width.
- F, 8: frames per layer, F ≥ 1.
- WC, $clog2(M): width of the word counter.
- FC, $clog2(F) (min 1): width of the frame counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle layer start; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after rst.
- in_valid  in  1  activation word valid.
- in_data  in  N  activation word.
- in_ready  out  1  sequencer can accept a word.
- sr_we  out  1  shift register write enable.
- sr_x  out  N  shift register data input.
- compute_start  out  1  one-cycle pulse: frame in shift register is complete.
- compute_done  in  1  neuron array finished the current frame.
- layer_done  out  1  one-cycle pulse after frame F completes.
- busy  out  1  high in every state except IDLE.
- word_idx  out  WC  words accepted in the current frame.
- frame_idx  out  FC  frames completed in the current layer.

## Operation
- States: IDLE, LOAD, FIRE, WAIT, DONE.
- IDLE: in_ready=0, busy=0. go=1 → LOAD, word_idx=0, frame_idx=0.
- LOAD: in_ready=1. Handshake = in_valid & in_ready. sr_we = handshake and sr_x = in_data, both combinational (same cycle). Each handshake increments word_idx. A handshake with word_idx==M-1 → FIRE, word_idx wraps to 0.
- FIRE: one cycle; compute_start=1, in_ready=0 → WAIT.
- WAIT: in_ready=0, sr_we=0. compute_done=1 → frame_idx==F-1 ? DONE : LOAD with frame_idx+1.
- DONE: one cycle; layer_done=1, frame_idx cleared → IDLE.
- Frame layout: the shift register shifts right by N on each write, so after M writes the first accepted word sits in y[N-1:0] and the last in y[M*N-1:(M-1)*N].
- The shift register is never cleared between frames; each frame overwrites all M words.
- go outside IDLE is ignored. compute_done outside WAIT is ignored, with no effect on counters.
- abort=1 in any state → IDLE on the next edge; word_idx and frame_idx cleared. No compute_start or layer_done is issued on that edge. sr_we is forced 0 in the abort cycle even if in_valid=1.
- sr_x equals in_data whenever sr_we=0 and is don't-care to the shift register.

## Timing
- Reset values: state IDLE, in_ready=0, sr_we=0, compute_start=0, layer_done=0, busy=0, word_idx=0, frame_idx=0.
- Reset mid-frame discards the partial frame; the shift register is reset by the same rst.
- Last-word handshake at edge k → compute_start high in cycle k+1; the shift register y is complete at that edge.
- Minimum frame period: M + 2 cycles, when in_valid is held high and compute_done is high in the first WAIT cycle.
- go at edge g with in_valid held high → first handshake in cycle g+1.
- in_valid low in LOAD stalls with no state change; word_idx holds.
- layer_done is asserted exactly one cycle after the compute_done of frame F-1. busy falls one cycle after layer_done.

## Test plan
- Reset then idle: rst pulse, in_valid=1 with no go → in_ready=0, sr_we=0, shift register y=0, all outputs 0.
- Single frame (M=4, N=32, F=1): go, stream 0x11,0x22,0x33,0x44 back-to-back → compute_start one cycle after 0x44 with y=0x00000044_00000033_00000022_00000011. compute_done the next cycle → layer_done one cycle later, then IDLE.
- Stalled input: in_valid toggling 1,0,0,1,1,0,1 → exactly 4 sr_we pulses, each matching the valid data, and compute_start fires once.
- Multi-frame (F=2): two frames 0x1..0x4 and 0x5..0x8 → two compute_start pulses; layer_done only after the second compute_done; frame_idx sequence 0→1→0.
- Spurious controls: compute_done in LOAD and go in WAIT → no state or counter change.
- Abort and reset mid-frame: abort after 2 words → IDLE, word_idx=0, no compute_start, and the next go requires 4 fresh words. rst in WAIT → IDLE and all outputs 0 asynchronously.

Source files
------------

// File: rtl/layer_input_sequencer.sv
// Layer-input sequencer: streams M activation words per frame into the layer
// shift register, fires the neuron array and repeats for F frames per layer.
module layer_input_sequencer #(
  parameter int unsigned M  = 4,
  parameter int unsigned N  = 32,
  parameter int unsigned F  = 8,
  parameter int unsigned WC = $clog2(M),
  parameter int unsigned FC = (F > 1) ? $clog2(F) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          sr_we,
  output logic [N-1:0]  sr_x,
  output logic          compute_start,
  input  logic          compute_done,
  output logic          layer_done,
  output logic          busy,
  output logic [WC-1:0] word_idx,
  output logic [FC-1:0] frame_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WC-1:0] word_q, word_d;
  logic [FC-1:0] frame_q, frame_d;
  logic          hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      frame_q <= frame_d;
    end
  end

  // Abort masks the handshake and both pulses in the same cycle, so nothing
  // downstream observes a partial transaction on the edge that returns to IDLE.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    frame_d       = frame_q;
    in_ready      = 1'b0;
    compute_start = 1'b0;
    layer_done    = 1'b0;
    hs            = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      word_d  = '0;
      frame_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            state_d = S_LOAD;
            word_d  = '0;
            frame_d = '0;
          end
        end
        S_LOAD: begin
          in_ready = 1'b1;
          hs       = in_valid;
          if (in_valid) begin
            if (word_q == WC'(M - 1)) begin
              word_d  = '0;
              state_d = S_FIRE;
            end else begin
              word_d = word_q + WC'(1);
            end
          end
        end
        S_FIRE: begin
          compute_start = 1'b1;
          state_d       = S_WAIT;
        end
        S_WAIT: begin
          if (compute_done) begin
            if (frame_q == FC'(F - 1)) begin
              state_d = S_DONE;
            end else begin
              frame_d = frame_q + FC'(1);
              state_d = S_LOAD;
            end
          end
        end
        S_DONE: begin
          layer_done = 1'b1;
          frame_d    = '0;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sr_we     = hs;
  assign sr_x      = in_data;
  assign busy      = (state_q != S_IDLE);
  assign word_idx  = word_q;
  assign frame_idx = frame_q;

endmodule

// File: tb/tb_layer_input_sequencer.sv
// Directed bench for layer_input_sequencer with a word/frame scoreboard and a
// behavioural model of the downstream shift register.
module tb_layer_input_sequencer;

  localparam int unsigned M  = 4;
  localparam int unsigned N  = 32;
  localparam int unsigned F  = 2;
  localparam int unsigned WC = $clog2(M);
  localparam int unsigned FC = (F > 1) ? $clog2(F) : 1;

  logic          clk;
  logic          rst;
  logic          go;
  logic          abort;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          sr_we;
  logic [N-1:0]  sr_x;
  logic          compute_start;
  logic          compute_done;
  logic          layer_done;
  logic          busy;
  logic [WC-1:0] word_idx;
  logic [FC-1:0] frame_idx;

  logic [M*N-1:0] y;

  int n_cmp;
  int n_bad;
  int n_we;
  int n_start;
  int n_ldone;
  logic [N-1:0]   wq[$];
  logic [M*N-1:0] fq[$];

  layer_input_sequencer #(.M(M), .N(N), .F(F)) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .sr_we         (sr_we),
    .sr_x          (sr_x),
    .compute_start (compute_start),
    .compute_done  (compute_done),
    .layer_done    (layer_done),
    .busy          (busy),
    .word_idx      (word_idx),
    .frame_idx     (frame_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register model: each write shifts right by one word, new word on top.
  always @(posedge clk or posedge rst) begin
    if (rst) y <= '0;
    else if (sr_we) y <= {sr_x, y[M*N-1:N]};
  end

  task automatic chk(input string tag, input logic [M*N-1:0] obs, input logic [M*N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then score the outputs.
  task automatic step(input logic v, input logic [N-1:0] d, input logic g,
                      input logic cd, input logic ab);
    @(posedge clk);
    #1;
    in_valid     = v;
    in_data      = d;
    go           = g;
    compute_done = cd;
    abort        = ab;
    #1;
    chk("sr_x_passthru", sr_x, in_data);
    if (sr_we) begin
      n_we++;
      if (wq.size() == 0) chk("we_unexpected", sr_we, 0);
      else chk("sr_x_word", sr_x, wq.pop_front());
    end
    if (compute_start) begin
      n_start++;
      if (fq.size() == 0) chk("cs_unexpected", compute_start, 0);
      else chk("frame_y", y, fq.pop_front());
    end
    if (layer_done) n_ldone++;
  endtask

  // Present one word in LOAD and expect it to be accepted this cycle.
  task automatic send(input logic [N-1:0] d);
    wq.push_back(d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] w;
    n_cmp = 0; n_bad = 0; n_we = 0; n_start = 0; n_ldone = 0;
    rst = 1'b1; go = 1'b0; abort = 1'b0; in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF; compute_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle with in_valid high and no go
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_sr_we", sr_we, 0);
    chk("idle_y", y, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cs", compute_start, 0);
    chk("idle_ld", layer_done, 0);
    chk("idle_word_idx", word_idx, 0);
    chk("idle_frame_idx", frame_idx, 0);

    // Frame 0: back-to-back words, minimum period
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("go_cycle_ready", in_ready, 0);
    fq.push_back({32'h44, 32'h33, 32'h22, 32'h11});
    for (int i = 0; i < 4; i++) begin
      w = 32'h11 * (i + 1);
      send(w);
      chk("f0_word_idx", word_idx, i);
      chk("f0_sr_we", sr_we, 1);
    end
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    chk("f0_compute_start", compute_start, 1);
    chk("f0_fire_ready", in_ready, 0);
    chk("f0_fire_word_idx", word_idx, 0);
    step(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
    chk("f0_wait_ready", in_ready, 0);
    chk("f0_wait_busy", busy, 1);
    chk("f0_wait_frame_idx", frame_idx, 0);

    // Frame 1: stalled input with spurious compute_done and go in LOAD
    fq.push_back({32'h8, 32'h7, 32'h6, 32'h5});
    send(32'h5);
    chk("f1_frame_idx", frame_idx, 1);
    step(1'b0, 32'hBAD0, 1'b0, 1'b1, 1'b0);
    chk("stall_word_idx", word_idx, 1);
    step(1'b0, 32'hBAD1, 1'b1, 1'b0, 1'b0);
    chk("stall2_word_idx", word_idx, 1);
    chk("stall2_frame_idx", frame_idx, 1);
    send(32'h6);
    send(32'h7);
    step(1'b0, 32'hBAD2, 1'b0, 1'b0, 1'b0);
    chk("stall3_word_idx", word_idx, 3);
    send(32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("f1_compute_start", compute_start, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("wait_hold_cs", compute_start, 0);
    chk("wait_hold_ready", in_ready, 0);
    chk("wait_hold_frame_idx", frame_idx, 1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("last_done_no_ld", layer_done, 0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("layer_done", layer_done, 1);
    chk("done_busy", busy, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("post_busy", busy, 0);
    chk("post_frame_idx", frame_idx, 0);
    chk("post_layer_done", layer_done, 0);
    chk("cnt_we", n_we, 8);
    chk("cnt_start", n_start, 2);
    chk("cnt_ldone", n_ldone, 1);

    // Abort after two words, then a fresh frame needs four new words
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    send(32'hC1);
    send(32'hC2);
    step(1'b1, 32'hC3, 1'b0, 1'b0, 1'b1);
    chk("abort_sr_we", sr_we, 0);
    step(1'b1, 32'hC4, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_word_idx", word_idx, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_no_cs", n_start, 2);
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    fq.push_back({32'hA4, 32'hA3, 32'hA2, 32'hA1});
    for (int i = 0; i < 4; i++) begin
      w = 32'hA1 + i;
      send(w);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("fresh_compute_start", compute_start, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while waiting for compute_done
    #1;
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_cs", compute_start, 0);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_frame_idx", frame_idx, 0);
    chk("rst_y", y, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("after_rst_busy", busy, 0);
    chk("wq_drained", wq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    chk("cnt_start_final", n_start, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
